// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
// Imported by the picker and the arbiter top.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

    localparam int NUM_REQ_DEF     = 4;
    localparam int DATA_W_DEF      = 8;
    localparam int MAX_PKT_LEN_DEF = 64;
    localparam int CNT_W_DEF       = 16;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first asserted request
// searching upward from last_owner+1, wrapping at NUM_REQ.
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    // Walk from the farthest candidate to the nearest so the
    // nearest asserted request is the final assignment.
    always_comb begin
        any = |req;
        idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            int               cand;
            logic [IDX_W-1:0] ci;
            cand = (int'(last_owner) + k) % NUM_REQ;
            ci   = IDX_W'(cand);
            if (req[ci]) begin
                idx = ci;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Packet-granular round-robin arbiter in front of the FIFO write port.
// A grant is held from the first byte until req_last or MAX_PKT_LEN.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MAX_PKT_LEN = MAX_PKT_LEN_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                       write_clk,
    input  logic                       write_rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_wr_en,
    output logic [DATA_W-1:0]          fifo_wr_data,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic [CNT_W-1:0]           pkt_count,
    output logic                       trunc_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int BC_W  = $clog2(MAX_PKT_LEN + 1);

    arb_state_t        state;
    logic [IDX_W-1:0]  last_owner;
    logic [BC_W-1:0]   beat_cnt;
    logic              pick_any;
    logic [IDX_W-1:0]  pick_idx;
    logic [DATA_W-1:0] data_arr [NUM_REQ];
    logic              owner_valid;
    logic              owner_last;
    logic              beat;
    logic              at_max;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req        (req_valid),
        .last_owner (last_owner),
        .any        (pick_any),
        .idx        (pick_idx)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    assign busy        = (state == ARB_BUSY);
    assign owner_valid = req_valid[grant_id];
    assign owner_last  = req_last[grant_id];
    assign beat        = busy & owner_valid & ~fifo_full;
    assign at_max      = (beat_cnt == BC_W'(MAX_PKT_LEN - 1));

    // Write path is combinational so a granted byte lands the same cycle.
    assign fifo_wr_en   = beat;
    assign fifo_wr_data = busy ? data_arr[grant_id] : '0;
    assign req_ready    = (busy & ~fifo_full) ?
                          (NUM_REQ'(1) << grant_id) : '0;

    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            state      <= ARB_IDLE;
            grant_id   <= '0;
            last_owner <= IDX_W'(NUM_REQ - 1);
            beat_cnt   <= '0;
            pkt_count  <= '0;
            trunc_err  <= 1'b0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        grant_id <= pick_idx;
                        beat_cnt <= '0;
                        state    <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (owner_last || at_max) begin
                            pkt_count  <= pkt_count + 1'b1;
                            last_owner <= grant_id;
                            state      <= ARB_IDLE;
                        end
                        // A last byte on the final allowed beat is a clean end.
                        if (at_max && !owner_last) begin
                            trunc_err <= 1'b1;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: two instances (long and 4-beat packet limit)
// share stimulus and are compared cycle by cycle with a reference model.
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 16;

    typedef struct {
        int         src;
        logic [7:0] d;
        int         c;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_last;
    logic          fifo_full;

    logic [N-1:0]  a_rdy, b_rdy;
    logic          a_wr, b_wr;
    logic [DW-1:0] a_data, b_data;
    logic [1:0]    a_gid, b_gid;
    logic          a_busy, b_busy;
    logic [CW-1:0] a_pc, b_pc;
    logic          a_te, b_te;

    always #5 clk = ~clk;

    fifo_write_arbiter #(
        .NUM_REQ(N), .DATA_W(DW), .MAX_PKT_LEN(64), .CNT_W(CW)
    ) ua (
        .write_clk(clk), .write_rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(a_rdy), .fifo_full(fifo_full),
        .fifo_wr_en(a_wr), .fifo_wr_data(a_data), .grant_id(a_gid),
        .busy(a_busy), .pkt_count(a_pc), .trunc_err(a_te)
    );

    fifo_write_arbiter #(
        .NUM_REQ(N), .DATA_W(DW), .MAX_PKT_LEN(4), .CNT_W(CW)
    ) ub (
        .write_clk(clk), .write_rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(b_rdy), .fifo_full(fifo_full),
        .fifo_wr_en(b_wr), .fifo_wr_data(b_data), .grant_id(b_gid),
        .busy(b_busy), .pkt_count(b_pc), .trunc_err(b_te)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int drv = 0;

    logic [8:0] src_q [N][$];
    logic [N-1:0] hold;
    wr_t wlog [2][$];
    int  glog [2][$];
    bit  prev_busy [2];

    // Reference model state, one per instance.
    bit m_busy [2];
    int m_owner [2];
    int m_last [2];
    int m_beats [2];
    int m_pkts [2];
    bit m_trunc [2];
    int m_max [2] = '{64, 4};

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_busy[m]  = 1'b0;
            m_owner[m] = 0;
            m_last[m]  = N - 1;
            m_beats[m] = 0;
            m_pkts[m]  = 0;
            m_trunc[m] = 1'b0;
        end
    endtask

    task automatic clear_logs();
        for (int m = 0; m < 2; m++) begin
            wlog[m].delete();
            glog[m].delete();
            prev_busy[m] = 1'b0;
        end
        cyc = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        hold = '0;
        fifo_full = 1'b0;
        drv = 0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0 && !hold[i]) begin
                req_valid[i] = 1'b1;
                req_data[i*DW +: DW] = src_q[i][0][7:0];
                req_last[i] = src_q[i][0][8];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i*DW +: DW] = 8'($urandom);
                req_last[i] = 1'($urandom);
            end
        end
    endtask

    // One clock: apply inputs, compare both DUTs to the model, advance.
    task automatic tick();
        logic [32:0] act, exp, msk;
        int bs [2];
        drive_inputs();
        #3;
        for (int m = 0; m < 2; m++) begin
            int own;
            bit b, ew;
            own = m_owner[m];
            b   = m_busy[m];
            ew  = b && req_valid[own] && !fifo_full;
            exp = {m_trunc[m], 16'(m_pkts[m]), b, 2'(own),
                   (b && !fifo_full) ? 4'(1 << own) : 4'b0, ew,
                   b ? req_data[own*DW +: DW] : 8'h00};
            if (m == 0) act = {a_te, a_pc, a_busy, a_gid, a_rdy, a_wr, a_data};
            else        act = {b_te, b_pc, b_busy, b_gid, b_rdy, b_wr, b_data};
            msk = '1;
            if (b && !ew) msk[7:0] = '0;
            if (!b) msk[14:13] = '0;
            checks++;
            if ((act & msk) !== (exp & msk)) begin
                errors++;
                $display("FAIL cycle_model dut=%0d cyc=%0d got=%h want=%h",
                         m, cyc, act & msk, exp & msk);
            end
            if (act[8] === 1'b1) wlog[m].push_back('{int'(act[14:13]), act[7:0], cyc});
            if (act[15] === 1'b1 && !prev_busy[m]) glog[m].push_back(int'(act[14:13]));
            prev_busy[m] = (act[15] === 1'b1);
        end
        @(posedge clk); #1;
        for (int m = 0; m < 2; m++) begin
            bs[m] = -1;
            if (!m_busy[m]) begin
                if (|req_valid) begin
                    bit found;
                    found = 1'b0;
                    for (int k = 1; k <= N; k++) begin
                        int c;
                        c = (m_last[m] + k) % N;
                        if (!found && req_valid[c]) begin
                            m_owner[m] = c;
                            found = 1'b1;
                        end
                    end
                    m_busy[m]  = 1'b1;
                    m_beats[m] = 0;
                end
            end else if (req_valid[m_owner[m]] && !fifo_full) begin
                int o;
                o = m_owner[m];
                bs[m] = o;
                m_beats[m]++;
                if (req_last[o] || m_beats[m] == m_max[m]) begin
                    if (!req_last[o]) m_trunc[m] = 1'b1;
                    m_pkts[m] = (m_pkts[m] + 1) % 65536;
                    m_last[m] = o;
                    m_busy[m] = 1'b0;
                end
            end
        end
        if (bs[drv] >= 0 && src_q[bs[drv]].size() > 0) void'(src_q[bs[drv]].pop_front());
        cyc++;
    endtask

    task automatic test_reset();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        hold = '0;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({a_busy, a_wr, a_rdy, a_gid, a_pc, a_te, a_data} !== '0) begin
            errors++;
            $display("FAIL reset_a got=%b want=0",
                     {a_busy, a_wr, a_rdy, a_gid, a_pc, a_te, a_data});
        end
        checks++;
        if ({b_busy, b_wr, b_rdy, b_gid, b_pc, b_te, b_data} !== '0) begin
            errors++;
            $display("FAIL reset_b got=%b want=0",
                     {b_busy, b_wr, b_rdy, b_gid, b_pc, b_te, b_data});
        end
        do_reset();
    endtask

    task automatic test_hello();
        string s;
        s = "Hello, World!";
        do_reset();
        for (int i = 0; i < 13; i++) src_q[0].push_back({i == 12, s[i]});
        repeat (20) tick();
        checks++;
        if (wlog[0].size() != 13) begin
            errors++;
            $display("FAIL hello_len got=%0d want=13", wlog[0].size());
        end else begin
            for (int i = 0; i < 13; i++) begin
                checks++;
                if (wlog[0][i].d !== s[i] || wlog[0][i].src != 0) begin
                    errors++;
                    $display("FAIL hello_byte%0d got=%h want=%h", i, wlog[0][i].d, s[i]);
                end
            end
            checks++;
            if (wlog[0][0].c != 1 || wlog[0][12].c != 13) begin
                errors++;
                $display("FAIL hello_timing got=%0d..%0d want=1..13",
                         wlog[0][0].c, wlog[0][12].c);
            end
        end
        checks++;
        if (a_pc !== 16'd1 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL hello_done got=pc%0d busy%b want=pc1 busy0", a_pc, a_busy);
        end
    endtask

    task automatic test_round_robin();
        int want [5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < N; i++) begin
            for (int p = 0; p < 3; p++) begin
                src_q[i].push_back({1'b0, 4'(i), 2'(p), 2'b00});
                src_q[i].push_back({1'b1, 4'(i), 2'(p), 2'b01});
            end
        end
        repeat (40) tick();
        checks++;
        if (glog[0].size() < 5 || wlog[0].size() != 24) begin
            errors++;
            $display("FAIL rr_counts got=%0d grants %0d writes want>=5 and 24",
                     glog[0].size(), wlog[0].size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (glog[0][k] != want[k]) begin
                    errors++;
                    $display("FAIL rr_order%0d got=%0d want=%0d", k, glog[0][k], want[k]);
                end
            end
            for (int k = 0; k < 24; k += 2) begin
                checks++;
                if (wlog[0][k].src != wlog[0][k+1].src ||
                    int'(wlog[0][k].d[7:4]) != wlog[0][k].src ||
                    int'(wlog[0][k+1].d[7:4]) != wlog[0][k].src) begin
                    errors++;
                    $display("FAIL rr_pair%0d got=%h,%h want=same source", k,
                             wlog[0][k].d, wlog[0][k+1].d);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        for (int i = 0; i < 8; i++) src_q[0].push_back({i == 7, 8'(8'hA0 + i)});
        n = 0;
        while (wlog[0].size() < 3 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (wlog[0].size() < 3) begin
            errors++;
            $display("FAIL bp_start got=%0d writes want=3", wlog[0].size());
        end
        fifo_full = 1'b1;
        repeat (5) begin
            tick();
            checks++;
            if (a_wr !== 1'b0 || a_rdy !== '0 || a_busy !== 1'b1 || a_gid !== 2'd0) begin
                errors++;
                $display("FAIL bp_hold got=wr%b rdy%b busy%b gid%0d want=wr0 rdy0 busy1 gid0",
                         a_wr, a_rdy, a_busy, a_gid);
            end
        end
        fifo_full = 1'b0;
        repeat (10) tick();
        checks++;
        if (wlog[0].size() != 8) begin
            errors++;
            $display("FAIL bp_len got=%0d want=8", wlog[0].size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (wlog[0][i].d !== 8'(8'hA0 + i)) begin
                    errors++;
                    $display("FAIL bp_byte%0d got=%h want=%h", i, wlog[0][i].d, 8'(8'hA0 + i));
                end
            end
        end
    endtask

    task automatic test_truncation();
        logic [7:0] want [6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h28, 8'h29};
        int wsrc [6] = '{1, 1, 1, 1, 2, 2};
        do_reset();
        drv = 1;
        for (int i = 0; i < 4; i++) src_q[2].push_back({i == 3, 8'(8'h20 + i)});
        repeat (8) tick();
        checks++;
        if (b_te !== 1'b0 || b_pc !== 16'd1) begin
            errors++;
            $display("FAIL trunc_exact got=te%b pc%0d want=te0 pc1", b_te, b_pc);
        end
        for (int m = 0; m < 2; m++) wlog[m].delete();
        for (int i = 0; i < 6; i++) src_q[1].push_back({1'b0, 8'(8'h10 + i)});
        repeat (2) tick();
        src_q[2].push_back({1'b0, 8'h28});
        src_q[2].push_back({1'b1, 8'h29});
        repeat (12) tick();
        checks++;
        if (wlog[1].size() < 6) begin
            errors++;
            $display("FAIL trunc_len got=%0d want>=6", wlog[1].size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (wlog[1][i].d !== want[i] || wlog[1][i].src != wsrc[i]) begin
                    errors++;
                    $display("FAIL trunc_byte%0d got=%0d:%h want=%0d:%h", i,
                             wlog[1][i].src, wlog[1][i].d, wsrc[i], want[i]);
                end
            end
        end
        checks++;
        if (b_te !== 1'b1 || b_pc !== 16'd3) begin
            errors++;
            $display("FAIL trunc_flag got=te%b pc%0d want=te1 pc3", b_te, b_pc);
        end
    endtask

    task automatic test_reset_mid();
        string s;
        int n;
        s = "Hello, World!";
        do_reset();
        for (int i = 0; i < 13; i++) src_q[0].push_back({i == 12, s[i]});
        n = 0;
        while (wlog[0].size() < 3 && n < 10) begin
            tick();
            n++;
        end
        drive_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_busy, a_wr, a_rdy, a_gid, a_pc, a_te, a_data} !== '0) begin
            errors++;
            $display("FAIL rst_mid_a got=%b want=0",
                     {a_busy, a_wr, a_rdy, a_gid, a_pc, a_te, a_data});
        end
        checks++;
        if ({b_busy, b_wr, b_rdy, b_gid, b_pc, b_te, b_data} !== '0) begin
            errors++;
            $display("FAIL rst_mid_b got=%b want=0",
                     {b_busy, b_wr, b_rdy, b_gid, b_pc, b_te, b_data});
        end
        for (int i = 0; i < N; i++) src_q[i].delete();
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_logs();
        src_q[3].push_back({1'b1, 8'h53});
        src_q[1].push_back({1'b1, 8'h51});
        repeat (8) tick();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (glog[m].size() < 2 || glog[m][0] != 1 || glog[m][1] != 3) begin
                errors++;
                $display("FAIL rst_regrant dut=%0d got=%0d grants want=1 then 3",
                         m, glog[m].size());
            end
        end
    endtask

    task automatic test_owner_gaps();
        int n;
        do_reset();
        for (int i = 0; i < 5; i++) src_q[2].push_back({i == 4, 8'(8'h60 + i)});
        n = 0;
        while (wlog[0].size() < 2 && n < 10) begin
            tick();
            n++;
        end
        hold[2] = 1'b1;
        for (int i = 0; i < 3; i++) src_q[0].push_back({i == 2, 8'(8'h70 + i)});
        repeat (3) begin
            tick();
            checks++;
            if (a_busy !== 1'b1 || a_gid !== 2'd2 || a_wr !== 1'b0) begin
                errors++;
                $display("FAIL gap_hold got=busy%b gid%0d wr%b want=busy1 gid2 wr0",
                         a_busy, a_gid, a_wr);
            end
        end
        hold[2] = 1'b0;
        repeat (15) tick();
        checks++;
        if (wlog[0].size() != 8) begin
            errors++;
            $display("FAIL gap_len got=%0d want=8", wlog[0].size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                logic [7:0] w;
                w = (i < 5) ? 8'(8'h60 + i) : 8'(8'h70 + i - 5);
                checks++;
                if (wlog[0][i].d !== w) begin
                    errors++;
                    $display("FAIL gap_byte%0d got=%h want=%h", i, wlog[0][i].d, w);
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 800; t++) begin
            if (t == 400) drv = 1;
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() == 0 && $urandom_range(3) == 0) begin
                    int len;
                    bit nolast;
                    len = $urandom_range(10, 1);
                    nolast = ($urandom_range(7) == 0);
                    for (int j = 0; j < len; j++)
                        src_q[i].push_back({(j == len - 1) && !nolast, 8'($urandom)});
                end
                hold[i] = ($urandom_range(5) == 0);
            end
            fifo_full = ($urandom_range(4) == 0);
            tick();
        end
        fifo_full = 1'b0;
    endtask

    initial begin
        test_reset();
        test_hello();
        test_round_robin();
        test_backpressure();
        test_truncation();
        test_reset_mid();
        test_owner_gaps();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
